// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: state and opclass
// enums, register indices, instruction lengths and opcode match patterns.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_MOV,
        OP_SETAB,
        OP_ALU,
        OP_LOAD,
        OP_STORE,
        OP_GOTO,
        OP_HALT
    } opclass_t;

    localparam logic [2:0] REG_A  = 3'd0;
    localparam logic [2:0] REG_B  = 3'd1;
    localparam logic [2:0] REG_C  = 3'd2;
    localparam logic [2:0] REG_D  = 3'd3;
    localparam logic [2:0] REG_M1 = 3'd4;
    localparam logic [2:0] REG_M2 = 3'd5;
    localparam logic [2:0] REG_X  = 3'd6;
    localparam logic [2:0] REG_Y  = 3'd7;

    localparam logic [3:0] LEN_SHORT = 4'd8;
    localparam logic [3:0] LEN_MEM   = 4'd12;
    localparam logic [3:0] LEN_GOTO  = 4'd14;

    // Opcode recognition: (inst & MASK) == MATCH
    localparam logic [7:0] MOV_MASK    = 8'hC0, MOV_MATCH   = 8'h00;
    localparam logic [7:0] SETAB_MASK  = 8'hC0, SETAB_MATCH = 8'h40;
    localparam logic [7:0] ALU_MASK    = 8'hF0, ALU_MATCH   = 8'h80;
    localparam logic [7:0] LOAD_MASK   = 8'hFC, LOAD_MATCH  = 8'h90;
    localparam logic [7:0] STORE_MASK  = 8'hFC, STORE_MATCH = 8'h98;
    localparam logic [7:0] GOTO_MASK   = 8'hE0, GOTO_MATCH  = 8'hC0;
    localparam logic [7:0] HALT_MASK   = 8'hFF, HALT_MATCH  = 8'hAE;

    typedef struct packed {
        logic [7:0] dst_ld;
        logic [7:0] src_sel;
        logic       imm_en;
        logic       alu_en;
        logic [2:0] alu_fn;
        logic       ld_cond;
        logic       mem_rd;
        logic       mem_wr;
        logic       addr_pc;
        logic       addr_m;
        logic       addr_j;
        logic       ld_inst;
        logic       ld_inc;
        logic       sel_inc;
        logic       ld_pc;
        logic [1:0] ld_j;
        logic       halted;
    } ctrl_t;

    function automatic logic [3:0] op_len(input opclass_t op);
        case (op)
            OP_LOAD, OP_STORE: op_len = LEN_MEM;
            OP_GOTO:           op_len = LEN_GOTO;
            default:           op_len = LEN_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational instruction decode: classifies the instruction byte and
// extracts the register indices, ALU function, immediate and branch fields.
module instr_decode
    import instr_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] inst,
    output opclass_t     opclass,
    output logic [2:0]   dst,
    output logic [2:0]   src,
    output logic [2:0]   fn,
    output logic [N-1:0] imm,
    output logic [3:0]   mask,
    output logic         link
);

    always_comb begin
        opclass = OP_NOP;
        dst     = REG_A;
        src     = REG_A;
        if ((inst[7:0] & HALT_MASK) == HALT_MATCH) begin
            opclass = OP_HALT;
        end else if ((inst[7:0] & MOV_MASK) == MOV_MATCH) begin
            opclass = OP_MOV;
            dst     = inst[5:3];
            src     = inst[2:0];
        end else if ((inst[7:0] & SETAB_MASK) == SETAB_MATCH) begin
            opclass = OP_SETAB;
            dst     = inst[5] ? REG_B : REG_A;
        end else if ((inst[7:0] & ALU_MASK) == ALU_MATCH) begin
            opclass = OP_ALU;
            dst     = inst[3] ? REG_D : REG_A;
        end else if ((inst[7:0] & LOAD_MASK) == LOAD_MATCH) begin
            opclass = OP_LOAD;
            dst     = {1'b0, inst[1:0]};
        end else if ((inst[7:0] & STORE_MASK) == STORE_MATCH) begin
            opclass = OP_STORE;
            src     = {1'b0, inst[1:0]};
        end else if ((inst[7:0] & GOTO_MASK) == GOTO_MATCH) begin
            opclass = OP_GOTO;
        end
    end

    assign fn   = inst[2:0];
    assign imm  = {{(N-5){inst[4]}}, inst[4:0]};
    assign mask = inst[4:1];
    assign link = inst[0];

endmodule

// File: rtl/instr_sequencer.sv
// Cycle-level control sequencer: fixed fetch, class-specific execute, then the
// next fetch. All strobes are registered, computed from the next state/step.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic [N-1:0] inst,
    input  logic [2:0]   flags,
    output logic [7:0]   dst_ld,
    output logic [7:0]   src_sel,
    output logic         imm_en,
    output logic [N-1:0] imm_val,
    output logic         alu_en,
    output logic [2:0]   alu_fn,
    output logic         ld_cond,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic         addr_pc,
    output logic         addr_m,
    output logic         addr_j,
    output logic         ld_inst,
    output logic         ld_inc,
    output logic         sel_inc,
    output logic         ld_pc,
    output logic [1:0]   ld_j,
    output logic         halted
);

    opclass_t     dec_opclass;
    logic [2:0]   dec_dst, dec_src, dec_fn;
    logic [N-1:0] dec_imm;
    logic [3:0]   dec_mask;
    logic         dec_link;

    instr_decode #(.N(N)) u_decode (
        .inst    (inst),
        .opclass (dec_opclass),
        .dst     (dec_dst),
        .src     (dec_src),
        .fn      (dec_fn),
        .imm     (dec_imm),
        .mask    (dec_mask),
        .link    (dec_link)
    );

    state_t       state_q, state_d;
    logic [3:0]   step_q, step_d;
    opclass_t     opclass_q, opclass_d;
    logic [2:0]   dst_q, dst_d, src_q, src_d, fn_q, fn_d;
    logic [N-1:0] imm_q, imm_d;
    logic [3:0]   mask_q, mask_d;
    logic         link_q, link_d;
    logic         armed_q, armed_d;
    ctrl_t        ctrl_q, ctrl_d;
    logic [N-1:0] imm_val_q, imm_val_d;
    logic         taken;

    // flags order is {sign, carry, zero}; the last mask bit tests not-zero
    assign taken = (mask_q == 4'd0) ||
                   (|(mask_q & {flags[2], flags[1], flags[0], ~flags[0]}));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        opclass_d = opclass_q;
        dst_d     = dst_q;
        src_d     = src_q;
        fn_d      = fn_q;
        imm_d     = imm_q;
        mask_d    = mask_q;
        link_d    = link_q;
        armed_d   = armed_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                    step_d  = 4'd1;
                end
            end
            ST_RUN: begin
                if (step_q == 4'd4) begin
                    opclass_d = dec_opclass;
                    dst_d     = dec_dst;
                    src_d     = dec_src;
                    fn_d      = dec_fn;
                    imm_d     = dec_imm;
                    mask_d    = dec_mask;
                    link_d    = dec_link;
                end
                if (step_q == op_len(opclass_q)) begin
                    if (opclass_q == OP_HALT) begin
                        state_d = ST_HALTED;
                        step_d  = 4'd0;
                        armed_d = 1'b0;
                    end else begin
                        step_d = 4'd1;
                    end
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_HALTED: begin
                // resume needs a fresh press: run low first, then high
                if (!run) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_RUN;
                    step_d  = 4'd1;
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 4'd0;
            end
        endcase
    end

    always_comb begin
        ctrl_d    = '0;
        imm_val_d = '0;
        if (state_d == ST_HALTED) begin
            ctrl_d.halted = 1'b1;
        end else if (state_d == ST_RUN) begin
            case (step_d)
                4'd1: begin
                    ctrl_d.addr_pc = 1'b1;
                    ctrl_d.mem_rd  = 1'b1;
                end
                4'd2: begin
                    ctrl_d.addr_pc = 1'b1;
                    ctrl_d.mem_rd  = 1'b1;
                    ctrl_d.ld_inst = 1'b1;
                    ctrl_d.ld_inc  = 1'b1;
                end
                4'd3: begin
                    ctrl_d.sel_inc = 1'b1;
                    ctrl_d.ld_pc   = 1'b1;
                end
                default: begin
                    case (opclass_d)
                        OP_MOV: if (step_d == 4'd5) begin
                            ctrl_d.src_sel[src_d] = 1'b1;
                            ctrl_d.dst_ld[dst_d]  = 1'b1;
                        end
                        OP_SETAB: if (step_d == 4'd5) begin
                            ctrl_d.imm_en        = 1'b1;
                            imm_val_d            = imm_d;
                            ctrl_d.dst_ld[dst_d] = 1'b1;
                        end
                        OP_ALU: if (step_d == 4'd5) begin
                            ctrl_d.alu_en        = 1'b1;
                            ctrl_d.alu_fn        = fn_d;
                            ctrl_d.ld_cond       = 1'b1;
                            ctrl_d.dst_ld[dst_d] = 1'b1;
                        end
                        OP_LOAD: if (step_d == 4'd5 || step_d == 4'd6) begin
                            ctrl_d.addr_m = 1'b1;
                            ctrl_d.mem_rd = 1'b1;
                            ctrl_d.dst_ld[dst_d] = (step_d == 4'd6);
                        end
                        OP_STORE: if (step_d == 4'd5 || step_d == 4'd6) begin
                            ctrl_d.addr_m         = 1'b1;
                            ctrl_d.src_sel[src_d] = 1'b1;
                            ctrl_d.mem_wr         = (step_d == 4'd6);
                        end
                        OP_GOTO: begin
                            // two operand-byte fetches land in J1 then J2
                            case (step_d)
                                4'd5, 4'd8: begin
                                    ctrl_d.addr_pc = 1'b1;
                                    ctrl_d.mem_rd  = 1'b1;
                                end
                                4'd6, 4'd9: begin
                                    ctrl_d.addr_pc = 1'b1;
                                    ctrl_d.mem_rd  = 1'b1;
                                    ctrl_d.ld_inc  = 1'b1;
                                    ctrl_d.ld_j    = (step_d == 4'd6) ? 2'b10 : 2'b01;
                                end
                                4'd7, 4'd10: begin
                                    ctrl_d.sel_inc = 1'b1;
                                    ctrl_d.ld_pc   = 1'b1;
                                end
                                4'd11: if (link_d) begin
                                    ctrl_d.sel_inc       = 1'b1;
                                    ctrl_d.dst_ld[REG_X] = 1'b1;
                                    ctrl_d.dst_ld[REG_Y] = 1'b1;
                                end
                                4'd12: if (taken) begin
                                    ctrl_d.addr_j = 1'b1;
                                    ctrl_d.ld_pc  = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            step_q    <= 4'd0;
            opclass_q <= OP_NOP;
            dst_q     <= REG_A;
            src_q     <= REG_A;
            fn_q      <= 3'd0;
            imm_q     <= '0;
            mask_q    <= 4'd0;
            link_q    <= 1'b0;
            armed_q   <= 1'b0;
            ctrl_q    <= '0;
            imm_val_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            opclass_q <= opclass_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            fn_q      <= fn_d;
            imm_q     <= imm_d;
            mask_q    <= mask_d;
            link_q    <= link_d;
            armed_q   <= armed_d;
            ctrl_q    <= ctrl_d;
            imm_val_q <= imm_val_d;
        end
    end

    assign dst_ld  = ctrl_q.dst_ld;
    assign src_sel = ctrl_q.src_sel;
    assign imm_en  = ctrl_q.imm_en;
    assign imm_val = imm_val_q;
    assign alu_en  = ctrl_q.alu_en;
    assign alu_fn  = ctrl_q.alu_fn;
    assign ld_cond = ctrl_q.ld_cond;
    assign mem_rd  = ctrl_q.mem_rd;
    assign mem_wr  = ctrl_q.mem_wr;
    assign addr_pc = ctrl_q.addr_pc;
    assign addr_m  = ctrl_q.addr_m;
    assign addr_j  = ctrl_q.addr_j;
    assign ld_inst = ctrl_q.ld_inst;
    assign ld_inc  = ctrl_q.ld_inc;
    assign sel_inc = ctrl_q.sel_inc;
    assign ld_pc   = ctrl_q.ld_pc;
    assign ld_j    = ctrl_q.ld_j;
    assign halted  = ctrl_q.halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: walks each instruction class step by
// step and compares strobes against hand-derived expectations.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset, run;
    logic [7:0] inst;
    logic [2:0] flags;
    logic [7:0] dst_ld, src_sel, imm_val;
    logic       imm_en, alu_en, ld_cond, mem_rd, mem_wr, addr_pc, addr_m, addr_j;
    logic       ld_inst, ld_inc, sel_inc, ld_pc, halted;
    logic [2:0] alu_fn;
    logic [1:0] ld_j;

    int n_cmp = 0;
    int n_bad = 0;

    logic [41:0] all_out;
    logic [5:0]  fetch;

    assign all_out = {dst_ld, src_sel, imm_en, imm_val, alu_en, alu_fn, ld_cond, mem_rd,
                      mem_wr, addr_pc, addr_m, addr_j, ld_inst, ld_inc, sel_inc, ld_pc,
                      ld_j, halted};
    assign fetch   = {addr_pc, mem_rd, ld_inst, ld_inc, sel_inc, ld_pc};

    instr_sequencer #(.N(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .inst    (inst),
        .flags   (flags),
        .dst_ld  (dst_ld),
        .src_sel (src_sel),
        .imm_en  (imm_en),
        .imm_val (imm_val),
        .alu_en  (alu_en),
        .alu_fn  (alu_fn),
        .ld_cond (ld_cond),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .addr_pc (addr_pc),
        .addr_m  (addr_m),
        .addr_j  (addr_j),
        .ld_inst (ld_inst),
        .ld_inc  (ld_inc),
        .sel_inc (sel_inc),
        .ld_pc   (ld_pc),
        .ld_j    (ld_j),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; inst = 8'h00; flags = 3'b000;
        tick(); tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL reset_outputs got %h want 0", all_out);
        end
        reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL idle_no_run got %h want 0", all_out);
        end
    endtask

    // Ends one cycle into S1 of the following instruction.
    task automatic test_mov();
        inst = 8'h01; run = 1'b1;
        tick();
        n_cmp++;
        if (fetch !== 6'b110000) begin
            n_bad++; $display("FAIL mov_s1 got %b want 110000", fetch);
        end
        tick();
        n_cmp++;
        if (fetch !== 6'b111100) begin
            n_bad++; $display("FAIL mov_s2 got %b want 111100", fetch);
        end
        tick();
        n_cmp++;
        if (fetch !== 6'b000011) begin
            n_bad++; $display("FAIL mov_s3 got %b want 000011", fetch);
        end
        tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL mov_s4 got %h want 0", all_out);
        end
        tick();
        n_cmp++;
        if ({src_sel, dst_ld, mem_rd} !== {8'h02, 8'h01, 1'b0}) begin
            n_bad++; $display("FAIL mov_s5 src/dst got %h/%h want 02/01", src_sel, dst_ld);
        end
        tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL mov_s6 got %h want 0", all_out);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (fetch !== 6'b110000) begin
            n_bad++; $display("FAIL mov_next_s1 got %b want 110000", fetch);
        end
    endtask

    task automatic test_setab();
        inst = 8'h5F;
        repeat (4) tick();
        n_cmp++;
        if ({imm_en, imm_val, dst_ld} !== {1'b1, 8'hFF, 8'h01}) begin
            n_bad++; $display("FAIL setab_s5 got en=%b imm=%h dst=%h want 1/ff/01", imm_en, imm_val, dst_ld);
        end
        repeat (3) tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL setab_s8 got %h want 0", all_out);
        end
        tick();
    endtask

    task automatic test_alu();
        inst = 8'h8D;
        repeat (4) tick();
        n_cmp++;
        if ({alu_en, alu_fn, ld_cond, dst_ld} !== {1'b1, 3'd5, 1'b1, 8'h08}) begin
            n_bad++; $display("FAIL alu_s5 got en=%b fn=%0d cond=%b dst=%h want 1/5/1/08", alu_en, alu_fn, ld_cond, dst_ld);
        end
        repeat (4) tick();
    endtask

    task automatic test_store();
        inst = 8'h99;
        repeat (4) tick();
        n_cmp++;
        if ({addr_m, src_sel, mem_wr, mem_rd} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL store_s5 got m=%b src=%h wr=%b want 1/02/0", addr_m, src_sel, mem_wr);
        end
        tick();
        n_cmp++;
        if ({addr_m, src_sel, mem_wr, mem_rd} !== {1'b1, 8'h02, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL store_s6 got m=%b src=%h wr=%b want 1/02/1", addr_m, src_sel, mem_wr);
        end
        tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL store_s7 got %h want 0", all_out);
        end
        repeat (5) tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL store_s12 got %h want 0", all_out);
        end
        tick();
        n_cmp++;
        if (fetch !== 6'b110000) begin
            n_bad++; $display("FAIL store_len12_s1 got %b want 110000", fetch);
        end
    endtask

    task automatic test_goto(input logic [7:0] op, input logic [2:0] fl,
                             input logic exp_taken, input logic exp_link, input string tag);
        inst = op; flags = fl;
        repeat (4) tick();
        n_cmp++;
        if ({addr_pc, mem_rd, ld_j} !== 4'b1100) begin
            n_bad++; $display("FAIL %s_s5 got %b want 1100", tag, {addr_pc, mem_rd, ld_j});
        end
        tick();
        n_cmp++;
        if ({addr_pc, mem_rd, ld_inc, ld_j} !== 5'b11110) begin
            n_bad++; $display("FAIL %s_s6 got %b want 11110", tag, {addr_pc, mem_rd, ld_inc, ld_j});
        end
        tick();
        n_cmp++;
        if ({sel_inc, ld_pc} !== 2'b11) begin
            n_bad++; $display("FAIL %s_s7 got %b want 11", tag, {sel_inc, ld_pc});
        end
        tick(); tick();
        n_cmp++;
        if (ld_j !== 2'b01) begin
            n_bad++; $display("FAIL %s_s9 ld_j got %b want 01", tag, ld_j);
        end
        tick(); tick();
        n_cmp++;
        if ({sel_inc, dst_ld} !== {exp_link, (exp_link ? 8'hC0 : 8'h00)}) begin
            n_bad++; $display("FAIL %s_s11 link got sel=%b dst=%h want link=%b", tag, sel_inc, dst_ld, exp_link);
        end
        tick();
        n_cmp++;
        if ({addr_j, ld_pc} !== {exp_taken, exp_taken}) begin
            n_bad++; $display("FAIL %s_s12 got %b want %b", tag, {addr_j, ld_pc}, {exp_taken, exp_taken});
        end
        tick(); tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL %s_s14 got %h want 0", tag, all_out);
        end
        tick();
        n_cmp++;
        if (fetch !== 6'b110000) begin
            n_bad++; $display("FAIL %s_len14_s1 got %b want 110000", tag, fetch);
        end
        flags = 3'b000;
    endtask

    // NOP decode, plus an inst change after S4 that must have no effect.
    task automatic test_nop_decode_timing();
        inst = 8'hE5;
        repeat (4) tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL nop_s5 got %h want 0", all_out);
        end
        inst = 8'h3F;
        repeat (3) tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL late_inst_s8 got %h want 0", all_out);
        end
        repeat (5) tick();
        n_cmp++;
        if ({src_sel, dst_ld} !== {8'h80, 8'h80}) begin
            n_bad++; $display("FAIL mov_same_s5 got %h/%h want 80/80", src_sel, dst_ld);
        end
        repeat (4) tick();
    endtask

    task automatic test_halt();
        inst = 8'hAE; run = 1'b1;
        repeat (7) tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL halt_s8 got %h want 0", all_out);
        end
        tick();
        n_cmp++;
        if (all_out !== 42'd1) begin
            n_bad++; $display("FAIL halt_enter got %h want 1", all_out);
        end
        repeat (3) tick();
        n_cmp++;
        if (halted !== 1'b1) begin
            n_bad++; $display("FAIL halt_hold_run got %b want 1", halted);
        end
        run = 1'b0;
        tick();
        n_cmp++;
        if (halted !== 1'b1) begin
            n_bad++; $display("FAIL halt_run_low got %b want 1", halted);
        end
        run = 1'b1;
        tick();
        n_cmp++;
        if ({halted, fetch} !== {1'b0, 6'b110000}) begin
            n_bad++; $display("FAIL halt_resume got %b want 0110000", {halted, fetch});
        end
    endtask

    task automatic test_load_reset();
        inst = 8'h92;
        repeat (4) tick();
        n_cmp++;
        if ({addr_m, mem_rd, dst_ld} !== {1'b1, 1'b1, 8'h00}) begin
            n_bad++; $display("FAIL load_s5 got %b want 1100000000", {addr_m, mem_rd, dst_ld});
        end
        tick();
        n_cmp++;
        if ({addr_m, mem_rd, dst_ld} !== {1'b1, 1'b1, 8'h04}) begin
            n_bad++; $display("FAIL load_s6 got %b want 1100000100", {addr_m, mem_rd, dst_ld});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL reset_mid_load got %h want 0", all_out);
        end
        reset = 1'b0; run = 1'b0;
        tick();
        n_cmp++;
        if (all_out !== 42'd0) begin
            n_bad++; $display("FAIL post_reset_idle got %h want 0", all_out);
        end
        run = 1'b1;
        tick();
        n_cmp++;
        if (fetch !== 6'b110000) begin
            n_bad++; $display("FAIL restart_s1 got %b want 110000", fetch);
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_setab();
        test_alu();
        test_store();
        test_goto(8'hC4, 3'b001, 1'b1, 1'b0, "goto_z_taken");
        test_goto(8'hC4, 3'b000, 1'b0, 1'b0, "goto_z_not");
        test_goto(8'hC1, 3'b000, 1'b1, 1'b1, "goto_link");
        test_goto(8'hC2, 3'b001, 1'b0, 1'b0, "goto_nz_not");
        test_nop_decode_timing();
        test_halt();
        test_load_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Cycle-level control sequencer that sits directly downstream of the instruction register. It consumes the 8-bit latched instruction and drives the per-cycle load/select strobes for the register, ALU, memory and program-counter units. It runs one fixed fetch phase, then a class-specific execute phase, then starts the next fetch. It is the block that generates `ldINST` and every other control-bus strobe.

## Interface

Parameters:
- `N`, 8: data width of the instruction and the immediate.

Ports:
- `clk` in 1: system clock. One clock domain; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start/continue request from the front panel.
- `inst` in N: content of the instruction register.
- `flags` in 3: {sign, carry, zero} from the condition register.
- `dst_ld` out 8: one-hot register load. Bit order: 0 A, 1 B, 2 C, 3 D, 4 M1, 5 M2, 6 X, 7 Y.
- `src_sel` out 8: one-hot register drive onto the data bus. Same bit order as `dst_ld`.
- `imm_en` out 1: drive the immediate onto the data bus.
- `imm_val` out N: the 5-bit immediate, sign-extended.
- `alu_en` out 1: drive the ALU result onto the data bus.
- `alu_fn` out 3: ALU function select.
- `ld_cond` out 1: load the condition register.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `addr_pc` out 1: PC drives the address bus.
- `addr_m` out 1: M1:M2 drives the address bus.
- `addr_j` out 1: J1:J2 drives the address bus.
- `ld_inst` out 1: instruction register load.
- `ld_inc` out 1: incrementer load.
- `sel_inc` out 1: incrementer drives the address bus.
- `ld_pc` out 1: PC load.
- `ld_j` out 2: [1] loads J1 (high byte), [0] loads J2 (low byte).
- `halted` out 1: HALTED state indicator.

## Operation

States: IDLE, RUN, HALTED. A step counter `step` runs 1..`len` and is only meaningful in RUN. Every output is a function of the registered state, `step`, and the latched opclass only (Moore). Every output not listed for a step is 0.

- **IDLE.** `run`=1 moves to RUN with step=1.
- **Fetch (all classes).**
  - S1: `addr_pc`, `mem_rd`.
  - S2: `addr_pc`, `mem_rd`, `ld_inst`, `ld_inc`.
  - S3: `sel_inc`, `ld_pc`.
  - S4: no strobes; decode `inst` into the opclass register.
- **MOV8** `00dddsss`, `len`=8.
  - S5: `src_sel[s]`, `dst_ld[d]`. When d==s both strobes are still asserted.
- **SETAB** `01rvvvvv`, `len`=8.
  - S5: `imm_en`, `imm_val`=sext(v), `dst_ld[r]` (r=0 A, r=1 B).
- **ALU** `1000rfff`, `len`=8.
  - S5: `alu_en`, `alu_fn`=f, `ld_cond`, `dst_ld[r?3:0]`.
- **LOAD** `100100rr`, `len`=12.
  - S5: `addr_m`, `mem_rd`.
  - S6: `addr_m`, `mem_rd`, `dst_ld[rr]`.
- **STORE** `100110rr`, `len`=12.
  - S5–S6: `addr_m`, `src_sel[rr]`.
  - S6: `mem_wr`.
- **GOTO** `110mmmmk`, `len`=14.
  - S5–S7: same pattern as S1–S3, with `ld_j[1]` in S6.
  - S8–S10: same pattern, with `ld_j[0]` in S9.
  - S11: `flags` sampled. taken = (mmmm==0) or |(mmmm & {sign, carry, zero, ~zero}). If k=1, `sel_inc`, `dst_ld[6]`, `dst_ld[7]`.
  - S12: if taken, `addr_j`, `ld_pc`.
- **HALT** `10101110`, `len`=8. After S8, enter HALTED.
- **All other encodings** (including `111xxxxx`): NOP, `len`=8.
- **End of instruction.** On step==`len`, go to S1 of the next instruction. `run` is ignored in RUN.
- **HALTED.** `halted`=1. Exit to RUN S1 only after `run` has been seen 0 and then 1 (level re-arm).

## Timing

- **Reset.** State IDLE, step 0, opclass NOP, every output 0, `halted`=0. Reset mid-instruction aborts the instruction on that edge; no partial strobe follows.
- **Start latency.** `run`=1 sampled in IDLE gives S1 strobes on the next cycle.
- **Instruction latency.** 8, 12 or 14 cycles, back-to-back with no bubble.
- **Decode timing.** `inst` is sampled only at S4. Changes on `inst` at any other step have no effect.

## Structure

- Shared package: opclass enum, register index constants (A..Y), `len` constants (8/12/14), opcode match masks, state enum.
- One sub-module, `instr_decode`: combinational `inst` → {opclass, d, s, r, f, imm, mask, link}.

## Test plan

- Reset, then `run`=1, with `inst`=`00000001` (MOV A←B): S1–S3 strobes, then S5 `src_sel`=`00000010`, `dst_ld`=`00000001`; next S1 at cycle 9.
- `inst`=`01011111` (SETAB A, -1): S5 `imm_val`=`8'hFF`, `dst_ld[0]`=1.
- `inst`=`10011001` (STORE B): `mem_wr` only in S6; `addr_m` in S5–S6; `len` 12.
- `inst`=`11000100`, `flags` zero=1: taken, `ld_pc` in S12. Same with zero=0: no `ld_pc`. `inst`=`11000001`: link strobes `dst_ld` bits 6/7 in S11.
- HALT: `halted`=1 after cycle 8. Holding `run`=1 stays halted; `run` 0→1 resumes at S1.
- Assert `reset` at S6 of a LOAD: every output 0 on the next cycle, state IDLE.
